// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that drives it.
// Optional feature macro: MDU_MADD_EN enables the madd/maddu accumulate ops.
package mdu_pkg;

    // MDU operation encodings, shared with the decoder.
    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MADD  = 4'd4;
    localparam logic [3:0] MDU_MADDU = 4'd5;

    // Default busy-window lengths.
    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } mdu_state_e;

    // True for opcodes that launch an operation in this build.
    function automatic logic mdu_op_valid(input logic [3:0] op);
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Divides take the long busy window; everything else uses the multiply window.
    function automatic logic mdu_op_is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core of the MDU: 64-bit products, quotient/remainder,
// and (with MDU_MADD_EN) multiply-accumulate into the current {HI,LO}.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [63:0] hilo_i,
    output logic [63:0] result_o,
    output logic        div_zero_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

`ifndef MDU_MADD_EN
    // Accumulator input only feeds madd/maddu.
    logic unused_hilo;
    assign unused_hilo = ^hilo_i;
`endif

    // Evaluate all candidate results, then select by opcode.
    always_comb begin
        prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        prod_u = {32'd0, a_i} * {32'd0, b_i};

        div_zero_o = (b_i == 32'd0) && mdu_op_is_div(op_i);
        // Substitute a harmless divisor so the dividers never see zero.
        divisor    = (b_i == 32'd0) ? 32'd1 : b_i;

        // INT_MIN / -1 overflows; the architectural answer is INT_MIN rem 0.
        if ((a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
            q_s = 32'h8000_0000;
            r_s = 32'd0;
        end else begin
            q_s = $signed(a_i) / $signed(divisor);
            r_s = $signed(a_i) % $signed(divisor);
        end
        q_u = a_i / divisor;
        r_u = a_i % divisor;

        result_o = 64'd0;
        case (op_i)
            MDU_MULT:  result_o = prod_s;
            MDU_MULTU: result_o = prod_u;
            MDU_DIV:   result_o = {r_s, q_s};
            MDU_DIVU:  result_o = {r_u, q_u};
`ifdef MDU_MADD_EN
            MDU_MADD:  result_o = hilo_i + prod_s;
            MDU_MADDU: result_o = hilo_i + prod_u;
`endif
            default:   result_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs multicycle mult/div operations,
// and services mthi/mtlo/mfhi/mflo. Optional macro MDU_MADD_EN adds madd/maddu.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_write,
    input  logic        lo_write,
    input  logic        hi_read,
    input  logic        lo_read,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    mdu_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;
    logic [31:0]    pend_hi_q;
    logic [31:0]    pend_lo_q;
    logic           pend_dz_q;

    logic [63:0]    calc_res;
    logic           calc_dz;
    logic           launch;
    logic [CntW-1:0] cnt_load;

    mdu_calc u_calc (
        .op_i       (mdu_op),
        .a_i        (a),
        .b_i        (b),
        .hilo_i     ({hi_q, lo_q}),
        .result_o   (calc_res),
        .div_zero_o (calc_dz)
    );

    // Launch decode and busy-window length for the op presented this cycle.
    always_comb begin
        launch   = start && mdu_op_valid(mdu_op) && (state_q == StIdle);
        cnt_load = mdu_op_is_div(mdu_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end

    // FSM, down-counter, pending result and HI/LO architectural state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (launch) begin
                        pend_hi_q <= calc_res[63:32];
                        pend_lo_q <= calc_res[31:0];
                        pend_dz_q <= calc_dz;
                        cnt_q     <= cnt_load;
                        state_q   <= StRun;
                    end else if (!start) begin
                        // Any start, even an ignored one, blocks mthi/mtlo this cycle.
                        if (hi_write) hi_q <= a;
                        if (lo_write) lo_q <= a;
                    end
                end
                StRun: begin
                    if (cnt_q <= CntW'(1)) begin
                        // Divide by zero burns the window but leaves HI/LO alone.
                        if (!pend_dz_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Register-sourced outputs and the mfhi/mflo read mux.
    always_comb begin
        busy    = (state_q == StRun);
        hi      = hi_q;
        lo      = lo_q;
        rd_data = hi_read ? hi_q : (lo_read ? lo_q : 32'd0);
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected busy length and HI/LO,
// a monitor pops and compares each time busy falls.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_write = 1'b0;
    logic        lo_write = 1'b0;
    logic        hi_read = 1'b0;
    logic        lo_read = 1'b0;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       name;
        int          len;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mdu_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdu_op   (mdu_op),
        .a        (a),
        .b        (b),
        .hi_write (hi_write),
        .lo_write (lo_write),
        .hi_read  (hi_read),
        .lo_read  (lo_read),
        .busy     (busy),
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drive one start pulse for a single cycle and record the expected completion.
    task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] aa,
                         input logic [31:0] bb, input int len, input logic [31:0] eh,
                         input logic [31:0] el);
        exp_t e;
        e.name = nm;
        e.len  = len;
        e.hi   = eh;
        e.lo   = el;
        @(negedge clk);
        sb.push_back(e);
        start  = 1'b1;
        mdu_op = op;
        a      = aa;
        b      = bb;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Wait for the monitor to retire every outstanding expectation.
    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d results outstanding, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    // Monitor: measure each busy window and compare HI/LO when it closes.
    initial begin
        int   run_len;
        logic prev_busy;
        exp_t e;
        run_len   = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                run_len++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got completion after %0d cycles, expected none",
                             run_len);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_len"}, 32'(run_len), 32'(e.len));
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                end
                run_len = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_rd", rd_data, 32'd0);

        issue("mult_neg", MDU_MULT, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        drain("mult_neg");
        issue("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        drain("multu");
        issue("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drain("div_neg");
        issue("divu_zero", MDU_DIVU, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drain("divu_zero");
        issue("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        drain("div_ovf");
        issue("divu", MDU_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        drain("divu");
        issue("div_negdiv", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
        drain("div_negdiv");
        issue("mult_pos", MDU_MULT, 32'h1234_5678, 32'h10, 5, 32'd1, 32'h2345_6780);
        drain("mult_pos");

        // mthi while idle, then read both registers through the mux.
        @(negedge clk);
        hi_write = 1'b1;
        a        = 32'h1234;
        @(negedge clk);
        hi_write = 1'b0;
        hi_read  = 1'b1;
        #1 check("mfhi", rd_data, 32'h1234);
        hi_read = 1'b0;
        lo_read = 1'b1;
        #1 check("mflo", rd_data, 32'h2345_6780);
        lo_read = 1'b0;

        // Simultaneous mthi/mtlo.
        @(negedge clk);
        hi_write = 1'b1;
        lo_write = 1'b1;
        a        = 32'hABCD;
        @(negedge clk);
        hi_write = 1'b0;
        lo_write = 1'b0;
        check("both_wr_hi", hi, 32'hABCD);
        check("both_wr_lo", lo, 32'hABCD);

        // Busy window: a second start and an mtlo must both be ignored.
        issue("multu_busy", MDU_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = MDU_DIV;
        a      = 32'd100;
        b      = 32'd3;
        @(negedge clk);
        start    = 1'b0;
        lo_write = 1'b1;
        a        = 32'hDEAD;
        @(negedge clk);
        lo_write = 1'b0;
        check("busy_lo_hold", lo, 32'hABCD);
        drain("multu_busy");

        // Invalid opcode: no launch, and the accompanying mthi is blocked by start.
        @(negedge clk);
        start    = 1'b1;
        mdu_op   = 4'd6;
        hi_write = 1'b1;
        a        = 32'h5555;
        @(negedge clk);
        start    = 1'b0;
        hi_write = 1'b0;
        check("inv_op_busy", {31'd0, busy}, 32'd0);
        check("inv_op_hi", hi, 32'd0);

`ifndef MDU_MADD_EN
        @(negedge clk);
        start  = 1'b1;
        mdu_op = MDU_MADD;
        @(negedge clk);
        start  = 1'b0;
        check("madd_off_busy", {31'd0, busy}, 32'd0);
`else
        @(negedge clk);
        hi_write = 1'b1;
        lo_write = 1'b1;
        a        = 32'd0;
        @(negedge clk);
        hi_write = 1'b0;
        a        = 32'hFFFF_FFFF;
        @(negedge clk);
        lo_write = 1'b0;
        issue("maddu", MDU_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0);
        drain("maddu");
        issue("madd", MDU_MADD, 32'hFFFF_FFFF, 32'd1, 5, 32'd0, 32'hFFFF_FFFF);
        drain("madd");
`endif

        // start and mthi together in idle: start wins and launches.
        hi_write = 1'b1;
        issue("mult_vs_wr", MDU_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd6);
        hi_write = 1'b0;
        check("start_wins_busy", {31'd0, busy}, 32'd1);
        drain("mult_vs_wr");

        // Reset in the middle of a divide discards it.
        issue("div_reset", MDU_DIV, 32'd100, 32'd3, 3, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drain("div_reset");
        repeat (15) @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        check("post_reset_hi", hi, 32'd0);
        check("post_reset_lo", lo, 32'd0);
        lo_read = 1'b1;
        #1 check("post_reset_rd", rd_data, 32'd0);
        lo_read = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It is the consumer of the decoder's `start`, MDU op, HI/LO read and HI/LO write controls.
- Runs a multicycle mult/multu/div/divu and owns the HI and LO registers.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Exports `busy` so the hazard unit can stall MDU-class instructions in D: stall when the decoder's MDU-stall flag is set and (`start` in E or `busy`).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state.
- start  in  1  launch operation selected by mdu_op (E-stage instruction).
- mdu_op  in  4  0=mult, 1=multu, 2=div, 3=divu; 4=madd, 5=maddu only with the optional feature; others=no-op.
- a  in  32  rs operand (forwarded).
- b  in  32  rt operand (forwarded).
- hi_write  in  1  mthi: HI <= a.
- lo_write  in  1  mtlo: LO <= a.
- hi_read  in  1  select HI onto rd_data.
- lo_read  in  1  select LO onto rd_data.
- busy  out  1  operation in flight.
- rd_data  out  32  hi_read ? HI : lo_read ? LO : 0 (combinational from registers).
- hi  out  32  current HI.
- lo  out  32  current LO.

Behaviour:
- Reset (reset==0 at an edge): HI=0, LO=0, busy=0, counter=0, pending result=0. This applies mid-operation too; the in-flight result is discarded.
- State machine:
  - IDLE: busy=0.
  - RUN: busy=1; a down-counter is loaded with N = MULT_CYCLES or DIV_CYCLES.
- Launch:
  - start=1 in IDLE with a valid op at edge T: the result is computed from a/b sampled at T and held in pending_hi/pending_lo; counter=N; state goes to RUN.
  - busy is high for exactly N cycles (edges T+1..T+N).
  - At edge T+N: HI/LO <= pending values, busy falls, state returns to IDLE.
  - The new HI/LO is visible combinationally in the cycle after busy drops.
- Arithmetic:
  - mult: signed 64-bit product, {HI,LO} = $signed(a)*$signed(b).
  - multu: unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (b==0, div or divu): the operation still runs the full DIV_CYCLES busy window; HI and LO are left unchanged at completion.
- Signed overflow case (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- start while busy: ignored, no restart and no effect on the counter. The hazard unit guarantees this does not occur.
- start with an invalid mdu_op: ignored; busy stays 0.
- hi_write/lo_write:
  - Accepted only when busy==0 and start==0; take effect at the next edge.
  - While busy, they are ignored.
  - If start and a write are both asserted in IDLE, start wins.
  - hi_write and lo_write together both take effect.
- hi_read/lo_read: pure mux, no side effects. The read data is stale while busy; the hazard unit prevents such reads.

Optional Feature:
- MDU_MADD_EN defined:
  - mdu_op 4 (madd) and 5 (maddu) are legal and take MULT_CYCLES.
  - Result {HI,LO} = {HI,LO} + product, signed or unsigned; the 64-bit sum wraps.
  - The HI/LO values used are those at the start edge.
- MDU_MADD_EN undefined: ops 4/5 are treated as invalid, so start is ignored.

Decomposition:
- Shared package (mdu_pkg):
  - MDU op constants (MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MADD=4, MDU_MADDU=5).
  - Default cycle-count constants.
  - The decoder uses the same constants.
- Sub-module mdu_calc: purely combinational. Takes op, a, b, and the current {HI,LO}; produces a 64-bit result and a div-by-zero flag.
- mdu_unit holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- mult with a=0xFFFFFFFF, b=2 → busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with a=0xFFFFFFFF, b=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div with a=0xFFFFFFF9 (-7), b=2 → busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with a=7, b=0 → busy for 10 cycles; HI/LO unchanged.
- hi_write with a=0x1234 while idle → next cycle rd_data=0x1234 when hi_read=1. lo_write asserted during busy → LO unaffected until completion.
- Start div, then reset=0 at busy cycle 4 → next cycle busy=0, HI=LO=0; no later update. start pulsed again mid-op → completion still at the original edge.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu with a=1, b=1 → HI=1, LO=0 after 5 cycles.
